// File: rtl/invader_fleet_pkg.sv
// Shared playfield dimensions and encodings for the invader formation controller.
package invader_fleet_pkg;

  localparam int FIELD_W = 32;
  localparam int FIELD_H = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MARCH   = 2'd1,
    ST_CLEARED = 2'd2,
    ST_LANDED  = 2'd3
  } fleet_state_e;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } fleet_dir_e;

endpackage

// File: rtl/fleet_hit_map.sv
// Maps a bullet cell onto the invader grid: reports whether it lands on an
// invader slot and, if so, the bitmap index r*COLS+c of that slot.
module fleet_hit_map
  import invader_fleet_pkg::*;
#(
  parameter int ROWS     = 3,
  parameter int COLS     = 8,
  parameter int COL_STEP = 2,
  parameter int ROW_STEP = 2
) (
  input  logic [4:0] bullet_x_i,
  input  logic [3:0] bullet_y_i,
  input  logic [4:0] fleet_x_i,
  input  logic [3:0] fleet_y_i,
  output logic       match_o,
  output logic [5:0] idx_o
);

  localparam int W = COL_STEP * (COLS - 1);
  localparam int H = ROW_STEP * (ROWS - 1);

  logic [5:0] dx;
  logic [5:0] dy;
  logic [5:0] col;
  logic [5:0] row;

  // Bit 5 of each difference is the borrow: bullet left of / above the fleet.
  always_comb begin
    dx  = {1'b0, bullet_x_i} - {1'b0, fleet_x_i};
    dy  = {2'b00, bullet_y_i} - {2'b00, fleet_y_i};
    col = (COL_STEP == 2) ? {1'b0, dx[5:1]} : dx;
    row = (ROW_STEP == 2) ? {1'b0, dy[5:1]} : dy;
    match_o = !dx[5] && !dy[5]
              && (dx <= 6'(W)) && (dy <= 6'(H))
              && !((COL_STEP == 2) && dx[0])
              && !((ROW_STEP == 2) && dy[0]);
    idx_o = 6'(32'(row) * COLS + 32'(col));
  end

endmodule

// File: rtl/invader_fleet.sv
// Invader formation controller: march FSM, position/direction, alive bitmap,
// population count and the registered bullet hit pulse.
module invader_fleet
  import invader_fleet_pkg::*;
#(
  parameter int ROWS     = 3,
  parameter int COLS     = 8,
  parameter int COL_STEP = 2,
  parameter int ROW_STEP = 2,
  parameter int LAND_ROW = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 Enable,
  input  logic [4:0]           bulletX,
  input  logic [3:0]           bulletY,
  input  logic                 BulletActive,
  output logic                 hit,
  output logic [ROWS*COLS-1:0] alive,
  output logic [4:0]           fleetX,
  output logic [3:0]           fleetY,
  output logic [5:0]           remaining,
  output logic                 allDead,
  output logic                 landed
);

  localparam int N       = ROWS * COLS;
  localparam int W       = COL_STEP * (COLS - 1);
  localparam int H       = ROW_STEP * (ROWS - 1);
  localparam int RIGHT_X = FIELD_W - 1 - W;

  fleet_state_e state_q, state_d;
  fleet_dir_e   dir_q, dir_d;
  logic [4:0]   fleet_x_q, fleet_x_d;
  logic [3:0]   fleet_y_q, fleet_y_d;
  logic [N-1:0] alive_q, alive_d;
  logic [5:0]   remaining_q, remaining_d;
  logic         hit_q, hit_d;

  logic         map_match;
  logic [5:0]   map_idx;
  logic [N-1:0] kill_sel;
  logic         kill;
  logic         at_edge;
  logic [5:0]   bottom_next;

  fleet_hit_map #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .COL_STEP(COL_STEP),
    .ROW_STEP(ROW_STEP)
  ) u_hit_map (
    .bullet_x_i(bulletX),
    .bullet_y_i(bulletY),
    .fleet_x_i (fleet_x_q),
    .fleet_y_i (fleet_y_q),
    .match_o   (map_match),
    .idx_o     (map_idx)
  );

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    fleet_x_d   = fleet_x_q;
    fleet_y_d   = fleet_y_q;
    alive_d     = alive_q;
    remaining_d = remaining_q;
    hit_d       = 1'b0;
    kill_sel    = N'(1) << map_idx;
    kill        = 1'b0;
    at_edge     = (dir_q == DIR_RIGHT) ? (fleet_x_q == 5'(RIGHT_X)) : (fleet_x_q == 5'd0);
    bottom_next = 6'(fleet_y_q) + 6'd1 + 6'(H);

    if (clear) begin
      state_d     = ST_IDLE;
      dir_d       = DIR_RIGHT;
      fleet_x_d   = '0;
      fleet_y_d   = '0;
      alive_d     = '1;
      remaining_d = 6'(N);
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_MARCH;
        ST_MARCH: begin
          // Collision uses the pre-move position; move and kill commit together.
          kill = BulletActive && map_match && ((alive_q & kill_sel) != '0);
          if (kill) begin
            alive_d     = alive_q & ~kill_sel;
            remaining_d = remaining_q - 6'd1;
            hit_d       = 1'b1;
          end
          if (kill && (remaining_q == 6'd1)) begin
            state_d = ST_CLEARED;
          end else if (Enable) begin
            if (at_edge) begin
              fleet_y_d = fleet_y_q + 4'd1;
              dir_d     = (dir_q == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
              if (bottom_next >= 6'(LAND_ROW)) state_d = ST_LANDED;
            end else if (dir_q == DIR_RIGHT) begin
              fleet_x_d = fleet_x_q + 5'd1;
            end else begin
              fleet_x_d = fleet_x_q - 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_RIGHT;
      fleet_x_q   <= '0;
      fleet_y_q   <= '0;
      alive_q     <= '1;
      remaining_q <= 6'(N);
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      fleet_x_q   <= fleet_x_d;
      fleet_y_q   <= fleet_y_d;
      alive_q     <= alive_d;
      remaining_q <= remaining_d;
      hit_q       <= hit_d;
    end
  end

  assign hit       = hit_q;
  assign alive     = alive_q;
  assign fleetX    = fleet_x_q;
  assign fleetY    = fleet_y_q;
  assign remaining = remaining_q;
  assign allDead   = (state_q == ST_CLEARED);
  assign landed    = (state_q == ST_LANDED);

endmodule

// File: tb/tb_invader_fleet.sv
// Scoreboard bench for invader_fleet: a cell-by-cell reference model predicts
// every cycle's outputs, plus fixed-value checks at the interesting points.
module tb_invader_fleet;

  localparam int ROWS = 3;
  localparam int COLS = 8;
  localparam int CS   = 2;
  localparam int RS   = 2;
  localparam int LAND = 14;
  localparam int W    = CS * (COLS - 1);
  localparam int H    = RS * (ROWS - 1);

  logic        clk = 1'b0;
  logic        reset, clear, start, Enable, BulletActive;
  logic [4:0]  bulletX;
  logic [3:0]  bulletY;
  logic        hit;
  logic [23:0] alive;
  logic [4:0]  fleetX;
  logic [3:0]  fleetY;
  logic [5:0]  remaining;
  logic        allDead, landed;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        hit;
    logic [23:0] alive;
    logic [4:0]  x;
    logic [3:0]  y;
    logic [5:0]  rem;
    logic        dead;
    logic        land;
  } exp_t;

  exp_t sb[$];

  // Reference model: state 0 idle, 1 march, 2 cleared, 3 landed; dir 0 right.
  int          m_state, m_x, m_y, m_dir, m_rem;
  logic [23:0] m_alive;
  logic        m_hit;

  invader_fleet dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .start       (start),
    .Enable      (Enable),
    .bulletX     (bulletX),
    .bulletY     (bulletY),
    .BulletActive(BulletActive),
    .hit         (hit),
    .alive       (alive),
    .fleetX      (fleetX),
    .fleetY      (fleetY),
    .remaining   (remaining),
    .allDead     (allDead),
    .landed      (landed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_state = 0; m_x = 0; m_y = 0; m_dir = 0; m_rem = 24;
    m_alive = 24'hFFFFFF; m_hit = 1'b0;
  endtask

  task automatic m_step(input logic clr, input logic st, input logic en, input logic ba,
                        input logic [4:0] bx, input logic [3:0] by);
    int kidx;
    m_hit = 1'b0;
    if (clr) begin
      m_reset();
    end else if (m_state == 0) begin
      if (st) m_state = 1;
    end else if (m_state == 1) begin
      kidx = -1;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (ba && (m_x + CS * c == int'(bx)) && (m_y + RS * r == int'(by))
              && ((m_alive & (24'd1 << (r * COLS + c))) != 24'd0))
            kidx = r * COLS + c;
      if (kidx >= 0) begin
        m_alive = m_alive & ~(24'd1 << kidx);
        m_rem--;
        m_hit = 1'b1;
        if (m_rem == 0) m_state = 2;
      end
      if (m_state == 1 && en) begin
        if ((m_dir == 0 && m_x == 31 - W) || (m_dir == 1 && m_x == 0)) begin
          m_y++;
          m_dir = 1 - m_dir;
          if (m_y + H >= LAND) m_state = 3;
        end else begin
          m_x = (m_dir == 0) ? m_x + 1 : m_x - 1;
        end
      end
    end
  endtask

  task automatic cycle(input logic clr, input logic st, input logic en, input logic ba,
                       input logic [4:0] bx, input logic [3:0] by);
    exp_t e;
    @(negedge clk);
    clear = clr; start = st; Enable = en; BulletActive = ba; bulletX = bx; bulletY = by;
    m_step(clr, st, en, ba, bx, by);
    e.hit = m_hit; e.alive = m_alive; e.x = 5'(m_x); e.y = 4'(m_y);
    e.rem = 6'(m_rem); e.dead = (m_state == 2); e.land = (m_state == 3);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_hit", 32'(hit), 32'(e.hit));
    check("sb_alive", 32'(alive), 32'(e.alive));
    check("sb_x", 32'(fleetX), 32'(e.x));
    check("sb_y", 32'(fleetY), 32'(e.y));
    check("sb_rem", 32'(remaining), 32'(e.rem));
    check("sb_dead", 32'(allDead), 32'(e.dead));
    check("sb_land", 32'(landed), 32'(e.land));
    clear = 0; start = 0; Enable = 0; BulletActive = 0;
  endtask

  task automatic tick();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 4'd0);
  endtask

  task automatic shoot(input logic en, input logic ba, input logic [4:0] bx, input logic [3:0] by);
    cycle(1'b0, 1'b0, en, ba, bx, by);
  endtask

  task automatic reload_and_start();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 4'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_alive"}, 32'(alive), 32'hFFFFFF);
    check({tag, "_rem"}, 32'(remaining), 32'd24);
    check({tag, "_x"}, 32'(fleetX), 32'd0);
    check({tag, "_y"}, 32'(fleetY), 32'd0);
    check({tag, "_hit"}, 32'(hit), 32'd0);
    check({tag, "_dead"}, 32'(allDead), 32'd0);
    check({tag, "_land"}, 32'(landed), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    reset = 1'b1; clear = 0; start = 0; Enable = 0; BulletActive = 0;
    bulletX = 0; bulletY = 0;
    m_reset();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;

    // Ticks without start leave the formation parked.
    tick(); tick(); tick();
    check("idle_no_move", 32'(fleetX), 32'd0);

    // Start and march to the right edge, descend, then head left.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 4'd0);
    check("start_ignores_tick", 32'(fleetX), 32'd0);
    for (int i = 0; i < 17; i++) tick();
    check("tick17_x", 32'(fleetX), 32'd17);
    tick();
    check("tick18_y", 32'(fleetY), 32'd1);
    check("tick18_x", 32'(fleetX), 32'd17);
    tick();
    check("tick19_x", 32'(fleetX), 32'd16);

    // Hit mapping at fleet (0,0).
    reload_and_start();
    shoot(1'b0, 1'b1, 5'd4, 4'd2);
    check("hit_4_2", 32'(hit), 32'd1);
    check("alive10", 32'(alive[10]), 32'd0);
    check("rem_23", 32'(remaining), 32'd23);
    shoot(1'b0, 1'b1, 5'd4, 4'd2);
    check("hold_no_hit", 32'(hit), 32'd0);
    shoot(1'b0, 1'b1, 5'd3, 4'd2);
    check("gap_no_hit", 32'(hit), 32'd0);
    shoot(1'b0, 1'b0, 5'd6, 4'd2);
    check("inactive_no_hit", 32'(hit), 32'd0);
    shoot(1'b0, 1'b1, 5'd0, 4'd6);
    check("below_grid_no_hit", 32'(hit), 32'd0);
    shoot(1'b0, 1'b1, 5'd6, 4'd2);
    check("hit_6_2", 32'(alive), 32'hFFF3FF);

    // Tick and kill on the same edge.
    reload_and_start();
    for (int i = 0; i < 5; i++) tick();
    shoot(1'b1, 1'b1, 5'd5, 4'd0);
    check("sim_hit", 32'(hit), 32'd1);
    check("sim_alive0", 32'(alive[0]), 32'd0);
    check("sim_x", 32'(fleetX), 32'd6);

    // Clear the wave; the final kill holds the formation in place.
    reload_and_start();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        shoot((r == ROWS - 1) && (c == COLS - 1), 1'b1, 5'(CS * c), 4'(RS * r));
    check("last_hit", 32'(hit), 32'd1);
    check("all_dead", 32'(allDead), 32'd1);
    check("rem_zero", 32'(remaining), 32'd0);
    check("cleared_no_move", 32'(fleetX), 32'd0);
    tick();
    check("cleared_frozen", 32'(fleetX), 32'd0);

    // March down to the landing row.
    reload_and_start();
    guard = 0;
    while (m_y < 10 && guard < 400) begin
      tick();
      guard++;
    end
    check("land_y", 32'(fleetY), 32'd10);
    check("land_x", 32'(fleetX), 32'd0);
    check("landed", 32'(landed), 32'd1);
    tick();
    check("land_frozen_x", 32'(fleetX), 32'd0);
    check("land_frozen_y", 32'(fleetY), 32'd10);
    shoot(1'b0, 1'b1, 5'd0, 4'd10);
    check("land_no_hit", 32'(hit), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0);
    check("clear_from_land", 32'(landed), 32'd0);
    check("clear_land_y", 32'(fleetY), 32'd0);

    // Asynchronous reset between edges.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 4'd0);
    for (int i = 0; i < 4; i++) tick();
    shoot(1'b1, 1'b1, 5'd6, 4'd0);
    check("pre_rst_x", 32'(fleetX), 32'd5);
    #1;
    reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_rst_idle", 32'(fleetX), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
